// File: rtl/ifu_if.sv
// ifu_if: fetch-side bundle for the IFU.
//   imem_req_*   : instruction memory request (valid/ready, address)
//   imem_rsp_*   : instruction memory response (valid/ready, data, bus error)
//   npc_valid/npc: next-PC strobe from the EXU
//   out_*        : fetched instruction handed to the IDU (valid/ready)
// Modports: master = IFU side, slave = memory/EXU/IDU environment side.
interface ifu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_rsp_valid;
  logic             imem_rsp_ready;
  logic [31:0]      imem_rsp_data;
  logic             imem_rsp_err;
  logic             npc_valid;
  logic [WIDTH-1:0] npc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic [31:0]      out_inst;
  logic             out_err;

  modport master (
    output imem_req_valid, imem_req_addr, imem_rsp_ready,
           out_valid, out_pc, out_inst, out_err,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           npc_valid, npc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, imem_rsp_ready,
           out_valid, out_pc, out_inst, out_err,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           npc_valid, npc, out_ready
  );
endinterface

// File: rtl/ifu.sv
// ifu: instruction fetch unit for the RV32 core.
// Holds the PC, issues one memory request per instruction, registers the
// returned word with its PC and offers it to decode. The EXU's next-PC strobe
// (accepted only while handing off an instruction or while idle) starts the
// next fetch.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : ifu_if.master (imem request/response, npc strobe, decode output)
// Parameters: WIDTH (PC width), RESET_PC (first fetch address).
// Optional feature: define IFU_ALIGN_CHECK_EN to fault misaligned PCs without
// a memory access; otherwise the request address is word-aligned by dropping
// pc[1:0] while out_pc keeps the full PC.
module ifu #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input logic   clk,
  input logic   rst,
  ifu_if.master bus
);

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    IDLE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt;
  logic [31:0]      inst, inst_nxt;
  logic             err, err_nxt;
  logic             misaligned;

`ifdef IFU_ALIGN_CHECK_EN
  assign misaligned        = (pc[1:0] != 2'b00);
  assign bus.imem_req_addr = pc;
`else
  assign misaligned        = 1'b0;
  assign bus.imem_req_addr = {pc[WIDTH-1:2], 2'b00};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
      inst  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      inst  <= inst_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = inst;
    err_nxt   = err;
    unique case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        // Misaligned fetch (only possible with the check enabled) bypasses
        // memory and is reported as a faulted all-zero word.
        if (misaligned) begin
          inst_nxt  = '0;
          err_nxt   = 1'b1;
          state_nxt = HOLD;
        end else if (bus.imem_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          inst_nxt  = bus.imem_rsp_data;
          err_nxt   = bus.imem_rsp_err;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (bus.npc_valid) begin
            pc_nxt    = bus.npc;
            state_nxt = REQ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      IDLE: begin
        if (bus.npc_valid) begin
          pc_nxt    = bus.npc;
          state_nxt = REQ;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign bus.imem_req_valid = (state == REQ) && !misaligned;
  assign bus.imem_rsp_ready = (state == WAIT);
  assign bus.out_valid      = (state == HOLD);
  assign bus.out_pc         = pc;
  assign bus.out_inst       = inst;
  assign bus.out_err        = err;

endmodule
